// File: rtl/cursor_ctl_pkg.sv
// Shared types and default geometry for the cursor controller.
package cursor_ctl_pkg;

   // Width of a cursor coordinate and of the idle-frame counter.
   localparam int POS_W  = 12;
   localparam int IDLE_W = 8;

   // Default screen limits and idle timeout (in frames).
   localparam int H_MAX_DEF       = 1023;
   localparam int V_MAX_DEF       = 767;
   localparam int HIDE_FRAMES_DEF = 255;

   // Commit sequencing: wait for movement, wait for vblank, commit.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

endpackage

// File: rtl/cursor_ctl_if.sv
// Mouse/timing inputs and cursor overlay outputs of the cursor controller.
interface cursor_ctl_if;
   import cursor_ctl_pkg::*;

   logic             vblnk_in;
   logic [POS_W-1:0] mouse_xpos;
   logic [POS_W-1:0] mouse_ypos;
   logic             mouse_valid;
   logic             mouse_left;
   logic [POS_W-1:0] xpos_out;
   logic [POS_W-1:0] ypos_out;
   logic             cursor_en;
   logic             left_click;

   // Driver side: mouse block and timing chain feeding the controller.
   modport master (
      output vblnk_in, mouse_xpos, mouse_ypos, mouse_valid, mouse_left,
      input  xpos_out, ypos_out, cursor_en, left_click
   );

   // Controller side.
   modport slave (
      input  vblnk_in, mouse_xpos, mouse_ypos, mouse_valid, mouse_left,
      output xpos_out, ypos_out, cursor_en, left_click
   );

endinterface

// File: rtl/cursor_ctl_edge_det.sv
// Rising-edge detector: one registered copy, combinational rise flag.
module edge_det (
   input  logic pclk,
   input  logic rst_lck_n,
   input  logic in,
   output logic rise
);

   logic in_q;

   // Remember last cycle's level so a low->high transition can be seen.
   always_ff @(posedge pclk) begin
      if (!rst_lck_n) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   assign rise = in & ~in_q;

endmodule

// File: rtl/cursor_ctl.sv
// Cursor controller: shadows mouse samples during the frame and commits
// the clamped position (plus any click) only at the start of vblank.
// Hides the cursor after a run of idle frames.
module cursor_ctl
   import cursor_ctl_pkg::*;
#(
   parameter int H_MAX       = H_MAX_DEF,
   parameter int V_MAX       = V_MAX_DEF,
   parameter int HIDE_FRAMES = HIDE_FRAMES_DEF
) (
   input logic         pclk,
   input logic         rst_lck_n,
   cursor_ctl_if.slave bus
);

   localparam logic [POS_W-1:0]  H_LIM    = POS_W'(H_MAX);
   localparam logic [POS_W-1:0]  V_LIM    = POS_W'(V_MAX);
   localparam logic [IDLE_W-1:0] HIDE_LIM = IDLE_W'(HIDE_FRAMES);

   // Unsigned clamp of a coordinate to its screen limit.
   function automatic logic [POS_W-1:0] clamp_pos(
      input logic [POS_W-1:0] v,
      input logic [POS_W-1:0] lim
   );
      return (v > lim) ? lim : v;
   endfunction

   // Idle counter increment that sticks at the hide threshold.
   function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
      return (v >= HIDE_LIM) ? HIDE_LIM : v + IDLE_W'(1);
   endfunction

   state_t            state_q, state_d;
   logic [POS_W-1:0]  xsh_q, xsh_d;
   logic [POS_W-1:0]  ysh_q, ysh_d;
   logic [POS_W-1:0]  xpos_q, xpos_d;
   logic [POS_W-1:0]  ypos_q, ypos_d;
   logic              cur_en_q, cur_en_d;
   logic              click_q, click_d;
   logic              click_pend_q, click_pend_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

   logic vblk_rise;
   logic left_rise;
   logic activity;

   edge_det u_vblk_edge (
      .pclk      (pclk),
      .rst_lck_n (rst_lck_n),
      .in        (bus.vblnk_in),
      .rise      (vblk_rise)
   );

   edge_det u_left_edge (
      .pclk      (pclk),
      .rst_lck_n (rst_lck_n),
      .in        (bus.mouse_left),
      .rise      (left_rise)
   );

   // Anything that needs a commit at the next vblank.
   assign activity = bus.mouse_valid | left_rise;

   // State and datapath registers; reset clears everything including the
   // pending sample and click so nothing leaks out after reset.
   always_ff @(posedge pclk) begin
      if (!rst_lck_n) begin
         state_q      <= ST_IDLE;
         xsh_q        <= '0;
         ysh_q        <= '0;
         xpos_q       <= '0;
         ypos_q       <= '0;
         cur_en_q     <= 1'b0;
         click_q      <= 1'b0;
         click_pend_q <= 1'b0;
         idle_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         xsh_q        <= xsh_d;
         ysh_q        <= ysh_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         cur_en_q     <= cur_en_d;
         click_q      <= click_d;
         click_pend_q <= click_pend_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end

   // Next-state logic: shadow capture, click tracking, commit and idle hide.
   always_comb begin
      state_d      = state_q;
      xsh_d        = xsh_q;
      ysh_d        = ysh_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      cur_en_d     = cur_en_q;
      click_d      = 1'b0;
      click_pend_d = click_pend_q;
      idle_cnt_d   = idle_cnt_q;

      // Latest sample always wins, whatever the state.
      if (bus.mouse_valid) begin
         xsh_d = bus.mouse_xpos;
         ysh_d = bus.mouse_ypos;
      end

      if (left_rise) begin
         click_pend_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (vblk_rise) begin
               idle_cnt_d = sat_inc(idle_cnt_q);
            end
            if (activity) begin
               state_d = ST_PENDING;
            end
         end

         ST_PENDING: begin
            if (vblk_rise) begin
               state_d = ST_COMMIT;
            end
         end

         ST_COMMIT: begin
            // Commit uses the shadow as it stood entering this cycle; a
            // sample arriving now is held for the next frame.
            xpos_d       = clamp_pos(xsh_q, H_LIM);
            ypos_d       = clamp_pos(ysh_q, V_LIM);
            cur_en_d     = 1'b1;
            idle_cnt_d   = '0;
            click_d      = click_pend_q;
            // A press landing in the commit cycle belongs to the next commit.
            click_pend_d = left_rise;
            state_d      = activity ? ST_PENDING : ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Hide on the same edge the counter reaches the threshold.
      if ((state_q != ST_COMMIT) && (idle_cnt_d == HIDE_LIM)) begin
         cur_en_d = 1'b0;
      end
   end

   assign bus.xpos_out   = xpos_q;
   assign bus.ypos_out   = ypos_q;
   assign bus.cursor_en  = cur_en_q;
   assign bus.left_click = click_q;

endmodule

// File: tb/tb_cursor_ctl.sv
// Bench for cursor_ctl: vector table of sample/click commits with a
// scoreboard of expected commits, plus hand sequences for multi-cycle cases.
module tb_cursor_ctl;
   import cursor_ctl_pkg::*;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      bit          valid;
      bit          click;
      logic [11:0] ex;
      logic [11:0] ey;
   } vec_t;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      bit          click;
   } exp_t;

   logic pclk = 1'b0;
   logic rst_lck_n;

   cursor_ctl_if bus ();

   cursor_ctl #(
      .H_MAX       (1023),
      .V_MAX       (767),
      .HIDE_FRAMES (255)
   ) dut (
      .pclk      (pclk),
      .rst_lck_n (rst_lck_n),
      .bus       (bus)
   );

   always #5 pclk = ~pclk;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   vec_t vt[8];
   int   prev_x = 0;
   int   prev_y = 0;

   task automatic tick();
      @(negedge pclk);
   endtask

   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic push(input int x, input int y, input bit c);
      exp_t e;
      e.x = 12'(x);
      e.y = 12'(y);
      e.click = c;
      sb.push_back(e);
   endtask

   task automatic strobe(input int x, input int y);
      bus.mouse_valid = 1'b1;
      bus.mouse_xpos  = 12'(x);
      bus.mouse_ypos  = 12'(y);
      tick();
      bus.mouse_valid = 1'b0;
   endtask

   // Called right after the edge that ends the COMMIT cycle.
   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_sb: got commit, expected none queued", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_x"}, int'(bus.xpos_out), int'(e.x));
         chk({tag, "_y"}, int'(bus.ypos_out), int'(e.y));
         chk({tag, "_en"}, int'(bus.cursor_en), 1);
         chk({tag, "_click"}, int'(bus.left_click), int'(e.click));
         prev_x = int'(e.x);
         prev_y = int'(e.y);
      end
   endtask

   // Vblank rise; outputs must hold after the first edge, update after the second.
   task automatic commit_check(input string tag);
      bus.vblnk_in = 1'b1;
      tick();
      chk({tag, "_hold_x"}, int'(bus.xpos_out), prev_x);
      chk({tag, "_hold_y"}, int'(bus.ypos_out), prev_y);
      tick();
      pop_check(tag);
      tick();
      chk({tag, "_click_1cyc"}, int'(bus.left_click), 0);
      bus.vblnk_in = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_off;
      int pulses;

      vt[0] = '{12'd100,  12'd200,  1'b1, 1'b0, 12'd100,  12'd200};
      vt[1] = '{12'd4000, 12'd900,  1'b1, 1'b0, 12'd1023, 12'd767};
      vt[2] = '{12'd1023, 12'd767,  1'b1, 1'b0, 12'd1023, 12'd767};
      vt[3] = '{12'd1024, 12'd768,  1'b1, 1'b0, 12'd1023, 12'd767};
      vt[4] = '{12'd0,    12'd0,    1'b1, 1'b0, 12'd0,    12'd0};
      vt[5] = '{12'd0,    12'd0,    1'b0, 1'b1, 12'd0,    12'd0};
      vt[6] = '{12'd500,  12'd300,  1'b1, 1'b1, 12'd500,  12'd300};
      vt[7] = '{12'd4095, 12'd4095, 1'b1, 1'b0, 12'd1023, 12'd767};

      rst_lck_n       = 1'b0;
      bus.vblnk_in    = 1'b0;
      bus.mouse_xpos  = '0;
      bus.mouse_ypos  = '0;
      bus.mouse_valid = 1'b0;
      bus.mouse_left  = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_x", int'(bus.xpos_out), 0);
      chk("rst_y", int'(bus.ypos_out), 0);
      chk("rst_en", int'(bus.cursor_en), 0);
      chk("rst_click", int'(bus.left_click), 0);
      chk("rst_state", int'(dut.state_q), int'(ST_IDLE));
      rst_lck_n = 1'b1;
      tick();

      // Table-driven commits.
      for (int i = 0; i < 8; i++) begin
         bus.mouse_left  = vt[i].click;
         bus.mouse_valid = vt[i].valid;
         bus.mouse_xpos  = vt[i].x;
         bus.mouse_ypos  = vt[i].y;
         push(int'(vt[i].ex), int'(vt[i].ey), vt[i].click);
         tick();
         bus.mouse_valid = 1'b0;
         tick();
         chk($sformatf("v%0d_midframe_x", i), int'(bus.xpos_out), prev_x);
         commit_check($sformatf("v%0d", i));
         bus.mouse_left = 1'b0;
         tick();
      end

      // Several strobes in one frame: the last one is committed.
      strobe(10, 10);
      tick();
      strobe(20, 20);
      strobe(30, 30);
      tick();
      push(30, 30, 1'b0);
      commit_check("last_wins");

      // Click without movement, then held button gives no further pulses.
      bus.mouse_left = 1'b1;
      tick();
      push(30, 30, 1'b1);
      commit_check("click_only");
      pulses = 0;
      for (int f = 0; f < 3; f++) begin
         bus.vblnk_in = 1'b1;
         for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.left_click) pulses++;
         end
         bus.vblnk_in = 1'b0;
         tick();
         if (bus.left_click) pulses++;
      end
      chk("held_no_pulse", pulses, 0);
      chk("held_state_idle", int'(dut.state_q), int'(ST_IDLE));
      bus.mouse_left = 1'b0;
      tick();

      // Sample on the vblank edge is committed; sample in COMMIT waits a frame.
      strobe(1, 2);
      bus.vblnk_in    = 1'b1;
      bus.mouse_valid = 1'b1;
      bus.mouse_xpos  = 12'd3;
      bus.mouse_ypos  = 12'd4;
      push(3, 4, 1'b0);
      tick();
      chk("coinc_hold_x", int'(bus.xpos_out), prev_x);
      bus.mouse_xpos = 12'd5;
      bus.mouse_ypos = 12'd6;
      tick();
      pop_check("coinc");
      bus.mouse_valid = 1'b0;
      chk("commit_to_pending", int'(dut.state_q), int'(ST_PENDING));
      tick();
      bus.vblnk_in = 1'b0;
      tick();
      push(5, 6, 1'b0);
      commit_check("requeue");

      // Idle hide after HIDE_FRAMES vblank edges, then restore.
      strobe(40, 40);
      push(40, 40, 1'b0);
      commit_check("pre_hide");
      first_off = 0;
      for (int k = 1; k <= 255; k++) begin
         bus.vblnk_in = 1'b1;
         tick();
         if (!bus.cursor_en && first_off == 0) first_off = k;
         bus.vblnk_in = 1'b0;
         tick();
         tick();
      end
      chk("hide_frame", first_off, 255);
      chk("hide_en", int'(bus.cursor_en), 0);
      chk("hide_x_hold", int'(bus.xpos_out), 40);
      chk("hide_y_hold", int'(bus.ypos_out), 40);
      strobe(50, 60);
      push(50, 60, 1'b0);
      commit_check("unhide");

      // Reset while pending with a click queued: nothing comes out.
      bus.mouse_left = 1'b1;
      strobe(700, 700);
      tick();
      chk("pre_rst_state", int'(dut.state_q), int'(ST_PENDING));
      rst_lck_n      = 1'b0;
      bus.mouse_left = 1'b0;
      tick();
      tick();
      rst_lck_n = 1'b1;
      tick();
      pulses = 0;
      bus.vblnk_in = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.left_click) pulses++;
      end
      bus.vblnk_in = 1'b0;
      tick();
      chk("prst_x", int'(bus.xpos_out), 0);
      chk("prst_y", int'(bus.ypos_out), 0);
      chk("prst_en", int'(bus.cursor_en), 0);
      chk("prst_no_click", pulses, 0);
      chk("prst_state", int'(dut.state_q), int'(ST_IDLE));
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
